// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, encodings and slot types for the ALU reservation station.
// Also holds the CDB snoop helper used for both wakeup and dispatch bypass.
package alu_reservation_station_pkg;

  localparam int OP_W   = 6;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  localparam logic [OP_W-1:0]  NOP      = '0;
  localparam logic [TAG_W-1:0] ZERO_TAG = '0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } operand_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    operand_t          src1;
    operand_t          src2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  rob_tag;
  } slot_t;

  // A pending operand takes the value of whichever bus carries its tag.
  function automatic operand_t snoop(
    input operand_t          o,
    input logic [TAG_W-1:0]  alu_tag,
    input logic [DATA_W-1:0] alu_value,
    input logic [TAG_W-1:0]  lsb_tag,
    input logic [DATA_W-1:0] lsb_value
  );
    operand_t r;
    r = o;
    if (o.tag != ZERO_TAG) begin
      if (o.tag == alu_tag) begin
        r.tag   = ZERO_TAG;
        r.value = alu_value;
      end else if (o.tag == lsb_tag) begin
        r.tag   = ZERO_TAG;
        r.value = lsb_value;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_priority_select.sv
// Lowest-index finder: one-hot grant, encoded index and a found flag.
// Used for both the free-slot and ready-slot searches.
module rs_priority_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found    = 1'b1;
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Out-of-order issue buffer feeding the integer ALU.
// Slots wait on CDB tags; the lowest ready slot issues each cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_clear,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_value1,
  input  logic [DATA_W-1:0] in_value2,
  input  logic [TAG_W-1:0]  in_tag1,
  input  logic [TAG_W-1:0]  in_tag2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_rob_tag,
  input  logic [TAG_W-1:0]  cdb_alu_tag,
  input  logic [TAG_W-1:0]  cdb_lsb_tag,
  input  logic [DATA_W-1:0] cdb_alu_value,
  input  logic [DATA_W-1:0] cdb_lsb_value,
  output logic              out_full,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_value1,
  output logic [DATA_W-1:0] out_value2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [TAG_W-1:0]  out_rob_tag
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  logic [ENTRIES-1:0] busy;
  slot_t              slots [ENTRIES];
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_next;

  logic [ENTRIES-1:0] ready;
  logic               issue_found;
  logic [ENTRIES-1:0] issue_grant;
  logic [IW-1:0]      issue_idx;
  logic               free_found;
  logic [ENTRIES-1:0] free_grant;
  logic [IW-1:0]      free_idx;
  logic               accept;
  slot_t              new_slot;

  always_comb begin
    ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = busy[i]
        && slots[i].src1.tag == ZERO_TAG
        && slots[i].src2.tag == ZERO_TAG;
    end
  end

  rs_priority_select #(.N(ENTRIES)) u_ready_sel (
    .req   (ready),
    .found (issue_found),
    .grant (issue_grant),
    .idx   (issue_idx)
  );

  rs_priority_select #(.N(ENTRIES)) u_free_sel (
    .req   (~busy),
    .found (free_found),
    .grant (free_grant),
    .idx   (free_idx)
  );

  // A full buffer refuses dispatch even if a slot frees this edge.
  assign accept = in_valid && !out_full && free_found;

  always_comb begin
    new_slot.op      = in_op;
    new_slot.src1    = snoop('{tag: in_tag1, value: in_value1},
                             cdb_alu_tag, cdb_alu_value,
                             cdb_lsb_tag, cdb_lsb_value);
    new_slot.src2    = snoop('{tag: in_tag2, value: in_value2},
                             cdb_alu_tag, cdb_alu_value,
                             cdb_lsb_tag, cdb_lsb_value);
    new_slot.imm     = in_imm;
    new_slot.pc      = in_pc;
    new_slot.rob_tag = in_rob_tag;
  end

  assign count_next = count - CW'(issue_found) + CW'(accept);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= '0;
      count       <= '0;
      out_full    <= 1'b0;
      out_op      <= NOP;
      out_value1  <= '0;
      out_value2  <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rob_tag <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        slots[i] <= '0;
      end
    end else if (rdy) begin
      if (in_clear) begin
        busy     <= '0;
        count    <= '0;
        out_full <= 1'b0;
        out_op   <= NOP;
      end else begin
        busy     <= (busy & ~issue_grant)
                  | (accept ? free_grant : '0);
        count    <= count_next;
        out_full <= (count_next == CW'(ENTRIES));
        if (issue_found) begin
          out_op      <= slots[issue_idx].op;
          out_value1  <= slots[issue_idx].src1.value;
          out_value2  <= slots[issue_idx].src2.value;
          out_imm     <= slots[issue_idx].imm;
          out_pc      <= slots[issue_idx].pc;
          out_rob_tag <= slots[issue_idx].rob_tag;
        end else begin
          out_op <= NOP;
        end
        for (int i = 0; i < ENTRIES; i++) begin
          if (busy[i]) begin
            slots[i].src1 <= snoop(slots[i].src1,
                                   cdb_alu_tag, cdb_alu_value,
                                   cdb_lsb_tag, cdb_lsb_value);
            slots[i].src2 <= snoop(slots[i].src2,
                                   cdb_alu_tag, cdb_alu_value,
                                   cdb_lsb_tag, cdb_lsb_value);
          end
        end
        if (accept) begin
          slots[free_idx] <= new_slot;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected issues are queued
// at stimulus time and popped by a monitor whenever out_op is nonzero.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  rob;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              in_clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [OP_W-1:0]   in_op = '0;
  logic [DATA_W-1:0] in_value1 = '0;
  logic [DATA_W-1:0] in_value2 = '0;
  logic [TAG_W-1:0]  in_tag1 = '0;
  logic [TAG_W-1:0]  in_tag2 = '0;
  logic [DATA_W-1:0] in_imm = '0;
  logic [DATA_W-1:0] in_pc = '0;
  logic [TAG_W-1:0]  in_rob_tag = '0;
  logic [TAG_W-1:0]  cdb_alu_tag = '0;
  logic [TAG_W-1:0]  cdb_lsb_tag = '0;
  logic [DATA_W-1:0] cdb_alu_value = '0;
  logic [DATA_W-1:0] cdb_lsb_value = '0;
  logic              out_full;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_value1;
  logic [DATA_W-1:0] out_value2;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_pc;
  logic [TAG_W-1:0]  out_rob_tag;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic rdy_q = 1'b0;

  alu_reservation_station #(.ENTRIES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .in_clear      (in_clear),
    .in_valid      (in_valid),
    .in_op         (in_op),
    .in_value1     (in_value1),
    .in_value2     (in_value2),
    .in_tag1       (in_tag1),
    .in_tag2       (in_tag2),
    .in_imm        (in_imm),
    .in_pc         (in_pc),
    .in_rob_tag    (in_rob_tag),
    .cdb_alu_tag   (cdb_alu_tag),
    .cdb_lsb_tag   (cdb_lsb_tag),
    .cdb_alu_value (cdb_alu_value),
    .cdb_lsb_value (cdb_lsb_value),
    .out_full      (out_full),
    .out_op        (out_op),
    .out_value1    (out_value1),
    .out_value2    (out_value2),
    .out_imm       (out_imm),
    .out_pc        (out_pc),
    .out_rob_tag   (out_rob_tag)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) rdy_q <= rdy;

  // Each issue seen after an enabled edge must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst && rdy_q && out_op !== NOP) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue got op=%0d v1=%h v2=%h rob=%0d",
                 out_op, out_value1, out_value2, out_rob_tag);
      end else begin
        e = exp_q.pop_front();
        if ({out_op, out_value1, out_value2, out_imm, out_pc, out_rob_tag}
            !== e) begin
          bad++;
          $display("FAIL issue_fields got op=%0d v1=%h v2=%h imm=%h pc=%h rob=%0d expected op=%0d v1=%h v2=%h imm=%h pc=%h rob=%0d",
                   out_op, out_value1, out_value2, out_imm, out_pc,
                   out_rob_tag, e.op, e.v1, e.v2, e.imm, e.pc, e.rob);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dispatch(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] v1,
    input logic [TAG_W-1:0]  t1,
    input logic [DATA_W-1:0] v2,
    input logic [TAG_W-1:0]  t2,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] pc,
    input logic [TAG_W-1:0]  rob
  );
    in_valid   = 1'b1;
    in_op      = op;
    in_value1  = v1;
    in_tag1    = t1;
    in_value2  = v2;
    in_tag2    = t2;
    in_imm     = imm;
    in_pc      = pc;
    in_rob_tag = rob;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    cdb_alu_tag = '0;
    cdb_lsb_tag = '0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    total++;
    if (out_op !== NOP) begin
      bad++;
      $display("FAIL reset_op got=%0d expected=0", out_op);
    end
    total++;
    if (out_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_full got=%b expected=0", out_full);
    end
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (out_op !== NOP || out_full !== 1'b0) begin
        bad++;
        $display("FAIL idle_cycle%0d got op=%0d full=%b expected 0/0",
                 i, out_op, out_full);
      end
    end
  endtask

  task automatic test_ready_dispatch();
    set_dispatch(6'd5, 32'd3, '0, 32'd4, '0, 32'h10, 32'h200, 4'd2);
    exp_q.push_back('{6'd5, 32'd3, 32'd4, 32'h10, 32'h200, 4'd2});
    step();
    idle_inputs();
    total++;
    if (out_op !== NOP) begin
      bad++;
      $display("FAIL ready_latency got=%0d expected=0", out_op);
    end
    step();
    total++;
    if (out_op !== 6'd5 || out_rob_tag !== 4'd2) begin
      bad++;
      $display("FAIL ready_issue got op=%0d rob=%0d expected op=5 rob=2",
               out_op, out_rob_tag);
    end
    step();
    total++;
    if (out_op !== NOP || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ready_after got op=%0d left=%0d expected 0/0",
               out_op, exp_q.size());
    end
  endtask

  task automatic test_wakeup();
    set_dispatch(6'd7, 32'hDEAD, 4'd7, 32'd9, '0, 32'd1, 32'h300, 4'd3);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_op !== NOP) begin
        bad++;
        $display("FAIL wakeup_wait%0d got=%0d expected=0", i, out_op);
      end
    end
    cdb_lsb_tag   = 4'd7;
    cdb_lsb_value = 32'h100;
    exp_q.push_back('{6'd7, 32'h100, 32'd9, 32'd1, 32'h300, 4'd3});
    step();
    idle_inputs();
    total++;
    if (out_op !== NOP) begin
      bad++;
      $display("FAIL wakeup_same_edge got=%0d expected=0", out_op);
    end
    step();
    total++;
    if (out_op !== 6'd7 || out_value1 !== 32'h100) begin
      bad++;
      $display("FAIL wakeup_issue got op=%0d v1=%h expected op=7 v1=100",
               out_op, out_value1);
    end
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL wakeup_drain got left=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_bypass();
    set_dispatch(6'd9, 32'd11, '0, 32'h1234, 4'd3, 32'd2, 32'h400, 4'd4);
    cdb_alu_tag   = 4'd3;
    cdb_alu_value = 32'hABCD;
    exp_q.push_back('{6'd9, 32'd11, 32'hABCD, 32'd2, 32'h400, 4'd4});
    step();
    idle_inputs();
    step();
    total++;
    if (out_op !== 6'd9 || out_value2 !== 32'hABCD) begin
      bad++;
      $display("FAIL bypass_issue got op=%0d v2=%h expected op=9 v2=abcd",
               out_op, out_value2);
    end
    step();
    total++;
    if (exp_q.size() != 0 || out_op !== NOP) begin
      bad++;
      $display("FAIL bypass_drain got left=%0d op=%0d expected 0/0",
               exp_q.size(), out_op);
    end
  endtask

  task automatic test_fill_order();
    int n;
    for (int i = 0; i < 16; i++) begin
      set_dispatch(OP_W'(10 + i), 32'hBAD, 4'd1, DATA_W'(i), '0,
                   DATA_W'(i), DATA_W'(32'h1000 + 4 * i), TAG_W'(i % 15 + 1));
      step();
    end
    total++;
    if (out_full !== 1'b1) begin
      bad++;
      $display("FAIL fill_full got=%b expected=1", out_full);
    end
    set_dispatch(6'd63, 32'd0, 4'd1, 32'd0, '0, 32'd0, 32'd0, 4'd15);
    step();
    idle_inputs();
    total++;
    if (out_full !== 1'b1 || out_op !== NOP) begin
      bad++;
      $display("FAIL fill_reject got full=%b op=%0d expected 1/0",
               out_full, out_op);
    end
    cdb_alu_tag   = 4'd1;
    cdb_alu_value = 32'h55;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{OP_W'(10 + i), 32'h55, DATA_W'(i), DATA_W'(i),
                        DATA_W'(32'h1000 + 4 * i), TAG_W'(i % 15 + 1)});
    end
    step();
    idle_inputs();
    total++;
    if (out_full !== 1'b1 || out_op !== NOP) begin
      bad++;
      $display("FAIL fill_wake got full=%b op=%0d expected 1/0",
               out_full, out_op);
    end
    step();
    total++;
    if (out_op !== 6'd10 || out_full !== 1'b0) begin
      bad++;
      $display("FAIL fill_first got op=%0d full=%b expected 10/0",
               out_op, out_full);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || n != 16) begin
      bad++;
      $display("FAIL fill_drain got left=%0d cycles=%0d expected 0/16",
               exp_q.size(), n);
    end
    total++;
    if (out_op !== NOP || out_full !== 1'b0) begin
      bad++;
      $display("FAIL fill_idle got op=%0d full=%b expected 0/0",
               out_op, out_full);
    end
  endtask

  task automatic test_flush_rdy();
    for (int i = 0; i < 5; i++) begin
      set_dispatch(OP_W'(20 + i), 32'd0, TAG_W'(5 + i), 32'd0, '0,
                   32'd0, 32'd0, TAG_W'(i + 1));
      step();
    end
    set_dispatch(6'd33, 32'hA1, '0, 32'hB2, '0, 32'hC3, 32'hD4, 4'd9);
    exp_q.push_back('{6'd33, 32'hA1, 32'hB2, 32'hC3, 32'hD4, 4'd9});
    step();
    idle_inputs();
    step();
    total++;
    if (out_op !== 6'd33) begin
      bad++;
      $display("FAIL flush_pre got op=%0d expected=33", out_op);
    end
    rdy = 1'b0;
    set_dispatch(6'd40, 32'd1, '0, 32'd2, '0, 32'd0, 32'd0, 4'd10);
    cdb_alu_tag   = 4'd5;
    cdb_alu_value = 32'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_op !== 6'd33 || out_value1 !== 32'hA1 ||
          out_pc !== 32'hD4 || out_full !== 1'b0) begin
        bad++;
        $display("FAIL freeze%0d got op=%0d v1=%h pc=%h full=%b expected 33/a1/d4/0",
                 i, out_op, out_value1, out_pc, out_full);
      end
    end
    idle_inputs();
    rdy = 1'b1;
    in_clear = 1'b1;
    step();
    in_clear = 1'b0;
    total++;
    if (out_op !== NOP || out_full !== 1'b0) begin
      bad++;
      $display("FAIL clear got op=%0d full=%b expected 0/0", out_op, out_full);
    end
    for (int t = 5; t < 10; t++) begin
      cdb_alu_tag   = TAG_W'(t);
      cdb_alu_value = DATA_W'(t);
      step();
      total++;
      if (out_op !== NOP) begin
        bad++;
        $display("FAIL post_clear_tag%0d got op=%0d expected=0", t, out_op);
      end
    end
    idle_inputs();
    step();
    step();
    total++;
    if (out_op !== NOP || exp_q.size() != 0) begin
      bad++;
      $display("FAIL post_clear_end got op=%0d left=%0d expected 0/0",
               out_op, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_fill_order();
    test_flush_rdy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
